maze_move_ctrl: RTL and testbench

- Sequences player movement for the maze game between the debounced button pulses and the maze wall memory.
- Takes one-cycle direction and restart pulses and checks the target cell through a read handshake.
- Commits the new position only on a frame tick so the VGA renderer never sees a mid-frame change.
- Drives player position, move count (to the 7-segment driver) and the win flag.

---
 rtl/maze_pkg.sv | 29 ++
 rtl/maze_dir_sel.sv | 54 +++++
 rtl/maze_move_ctrl.sv | 149 ++++++++++++++
 tb/tb_maze_move_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared maze constants, direction/state encodings and cell addressing.
package maze_pkg;

    localparam int GRID_W = 16;
    localparam int GRID_H = 12;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_COMMIT = 3'd2,
        S_DRAIN  = 3'd3,
        S_WON    = 3'd4
    } state_t;

    // Row-major cell index; callers truncate to their address width.
    function automatic int unsigned cell_addr(input int unsigned x,
                                              input int unsigned y,
                                              input int unsigned gw);
        return y * gw + x;
    endfunction

endpackage

// File: rtl/maze_dir_sel.sv
// Priority pick of simultaneous direction pulses, target cell and off-grid flag.
module maze_dir_sel
    import maze_pkg::*;
#(
    parameter int GW = 16,
    parameter int GH = 12,
    parameter int XW = 4,
    parameter int YW = 4
) (
    input  logic          i_up,
    input  logic          i_down,
    input  logic          i_left,
    input  logic          i_right,
    input  logic [XW-1:0] i_x,
    input  logic [YW-1:0] i_y,
    output logic          o_req,
    output dir_t          o_dir,
    output logic          o_off,
    output logic [XW-1:0] o_tx,
    output logic [YW-1:0] o_ty
);

    always_comb begin
        o_req = i_up | i_down | i_left | i_right;
        if (i_up)        o_dir = DIR_UP;
        else if (i_down) o_dir = DIR_DOWN;
        else if (i_left) o_dir = DIR_LEFT;
        else             o_dir = DIR_RIGHT;

        o_tx  = i_x;
        o_ty  = i_y;
        o_off = 1'b0;
        // Edge test comes first so the wrapped coordinate is never used.
        case (o_dir)
            DIR_UP: begin
                o_off = (i_y == '0);
                o_ty  = i_y - YW'(1);
            end
            DIR_DOWN: begin
                o_off = (i_y == YW'(GH - 1));
                o_ty  = i_y + YW'(1);
            end
            DIR_LEFT: begin
                o_off = (i_x == '0);
                o_tx  = i_x - XW'(1);
            end
            default: begin
                o_off = (i_x == XW'(GW - 1));
                o_tx  = i_x + XW'(1);
            end
        endcase
    end

endmodule

// File: rtl/maze_move_ctrl.sv
// Player movement sequencer: wall lookup handshake, frame-synchronous commit,
// move counter and win detection.
module maze_move_ctrl
    import maze_pkg::*;
#(
    parameter int GRID_W  = maze_pkg::GRID_W,
    parameter int GRID_H  = maze_pkg::GRID_H,
    parameter int START_X = 0,
    parameter int START_Y = 0,
    parameter int GOAL_X  = 15,
    parameter int GOAL_Y  = 11,
    parameter int CNT_W   = 16,
    localparam int X_W    = $clog2(GRID_W),
    localparam int Y_W    = $clog2(GRID_H),
    localparam int ADDR_W = $clog2(GRID_W * GRID_H)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              up_p,
    input  logic              down_p,
    input  logic              left_p,
    input  logic              right_p,
    input  logic              restart_p,
    input  logic              frame_tick,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    input  logic              rd_open,
    output logic [X_W-1:0]    player_x,
    output logic [Y_W-1:0]    player_y,
    output logic [CNT_W-1:0]  move_count,
    output logic              won,
    output logic              busy,
    output logic              bump
);

    state_t              r_state;
    state_t              w_next;
    logic [X_W-1:0]      r_x, r_tx, w_tx;
    logic [Y_W-1:0]      r_y, r_ty, w_ty;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_rd_req, r_won, r_busy, r_bump;
    logic                w_req, w_off, w_goal;
    dir_t                w_dir;

    maze_dir_sel #(
        .GW (GRID_W),
        .GH (GRID_H),
        .XW (X_W),
        .YW (Y_W)
    ) u_dir_sel (
        .i_up    (up_p),
        .i_down  (down_p),
        .i_left  (left_p),
        .i_right (right_p),
        .i_x     (r_x),
        .i_y     (r_y),
        .o_req   (w_req),
        .o_dir   (w_dir),
        .o_off   (w_off),
        .o_tx    (w_tx),
        .o_ty    (w_ty)
    );

    assign w_goal = (r_tx == X_W'(GOAL_X)) && (r_ty == Y_W'(GOAL_Y));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (!restart_p && w_req && !w_off) w_next = S_LOOKUP;
            S_LOOKUP: begin
                if (restart_p)     w_next = rd_valid ? S_IDLE : S_DRAIN;
                else if (rd_valid) w_next = rd_open ? S_COMMIT : S_IDLE;
            end
            S_COMMIT: begin
                if (restart_p)       w_next = S_IDLE;
                else if (frame_tick) w_next = w_goal ? S_WON : S_IDLE;
            end
            // Restart cannot abandon DRAIN: the stale response must still be swallowed.
            S_DRAIN:  if (rd_valid) w_next = S_IDLE;
            S_WON:    if (restart_p) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_x       <= X_W'(START_X);
            r_y       <= Y_W'(START_Y);
            r_tx      <= X_W'(START_X);
            r_ty      <= Y_W'(START_Y);
            r_cnt     <= '0;
            r_won     <= 1'b0;
            r_busy    <= 1'b0;
            r_bump    <= 1'b0;
            r_rd_req  <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_bump   <= 1'b0;
            r_rd_req <= (w_next == S_LOOKUP);
            r_busy   <= (w_next == S_LOOKUP) || (w_next == S_COMMIT) || (w_next == S_DRAIN);
            if (restart_p) begin
                r_x   <= X_W'(START_X);
                r_y   <= Y_W'(START_Y);
                r_cnt <= '0;
                r_won <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_req && w_off) begin
                            r_bump <= 1'b1;
                        end else if (w_req) begin
                            r_tx      <= w_tx;
                            r_ty      <= w_ty;
                            r_rd_addr <= ADDR_W'(cell_addr(32'(w_tx), 32'(w_ty),
                                                           32'(GRID_W)));
                        end
                    end
                    S_LOOKUP: if (rd_valid && !rd_open) r_bump <= 1'b1;
                    S_COMMIT: begin
                        if (frame_tick) begin
                            r_x <= r_tx;
                            r_y <= r_ty;
                            if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
                            if (w_goal) r_won <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rd_req     = r_rd_req;
    assign rd_addr    = r_rd_addr;
    assign player_x   = r_x;
    assign player_y   = r_y;
    assign move_count = r_cnt;
    assign won        = r_won;
    assign busy       = r_busy;
    assign bump       = r_bump;

endmodule

// File: tb/tb_maze_move_ctrl.sv
// Directed + randomized bench for maze_move_ctrl against a move-level reference model.
module tb_maze_move_ctrl;

    localparam int GW = 16;
    localparam int GH = 12;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        up_p = 1'b0, down_p = 1'b0, left_p = 1'b0, right_p = 1'b0;
    logic        restart_p = 1'b0, frame_tick = 1'b0;
    logic        rd_valid = 1'b0, rd_open = 1'b0;
    logic        rd_req, won, busy, bump;
    logic [7:0]  rd_addr;
    logic [3:0]  player_x, player_y;
    logic [15:0] move_count;
    logic        rd_req2, won2, busy2, bump2;
    logic [7:0]  rd_addr2;
    logic [3:0]  player_x2, player_y2;
    logic [1:0]  move_count2;

    maze_move_ctrl dut (
        .Clk(Clk), .Reset(Reset), .up_p(up_p), .down_p(down_p), .left_p(left_p),
        .right_p(right_p), .restart_p(restart_p), .frame_tick(frame_tick),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_open(rd_open),
        .player_x(player_x), .player_y(player_y), .move_count(move_count),
        .won(won), .busy(busy), .bump(bump)
    );

    // Narrow counter copy sees identical stimulus; only its count may differ.
    maze_move_ctrl #(.CNT_W(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .up_p(up_p), .down_p(down_p), .left_p(left_p),
        .right_p(right_p), .restart_p(restart_p), .frame_tick(frame_tick),
        .rd_req(rd_req2), .rd_addr(rd_addr2), .rd_valid(rd_valid), .rd_open(rd_open),
        .player_x(player_x2), .player_y(player_y2), .move_count(move_count2),
        .won(won2), .busy(busy2), .bump(bump2)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;
    bit wall_open [GW*GH];
    int mx, my, mcnt, mwon;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mcnt = 0; mwon = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".x"}, player_x, mx);
        chk({tag, ".y"}, player_y, my);
        chk({tag, ".cnt"}, move_count, mcnt);
        chk({tag, ".cnt2"}, move_count2, (mcnt > 3) ? 3 : mcnt);
        chk({tag, ".won"}, won, mwon);
    endtask

    // mask = {up, down, left, right}
    task automatic pulse(input logic [3:0] m);
        {up_p, down_p, left_p, right_p} = m;
        @(negedge Clk);
        {up_p, down_p, left_p, right_p} = 4'b0;
    endtask

    task automatic do_restart(input string tag);
        restart_p = 1'b1;
        @(negedge Clk);
        restart_p = 1'b0;
        model_reset();
        check_state(tag);
        chk({tag, ".req"}, rd_req, 0);
        chk({tag, ".busy"}, busy, 0);
    endtask

    task automatic do_move(input string tag, input logic [3:0] m, input int lat,
                           input int gap, input bit tick_on_valid);
        int dx, dy, tx, ty, a;
        bit off;
        dx = 0; dy = 0;
        if (m[3])      dy = -1;
        else if (m[2]) dy = 1;
        else if (m[1]) dx = -1;
        else           dx = 1;
        tx = mx + dx;
        ty = my + dy;
        off = (tx < 0) || (tx >= GW) || (ty < 0) || (ty >= GH);
        pulse(m);
        if (mwon != 0) begin
            chk({tag, ".won_noreq"}, rd_req, 0);
            chk({tag, ".won_nobusy"}, busy, 0);
            cyc(2);
            chk({tag, ".won_noreq2"}, rd_req, 0);
            check_state({tag, ".won"});
            return;
        end
        if (off) begin
            chk({tag, ".off_bump"}, bump, 1);
            chk({tag, ".off_noreq"}, rd_req, 0);
            cyc(1);
            chk({tag, ".off_bump_end"}, bump, 0);
            chk({tag, ".off_noreq2"}, rd_req, 0);
            check_state({tag, ".off"});
            return;
        end
        a = ty * GW + tx;
        chk({tag, ".req"}, rd_req, 1);
        chk({tag, ".addr"}, rd_addr, a);
        chk({tag, ".busy"}, busy, 1);
        cyc(lat - 1);
        chk({tag, ".req_hold"}, rd_req, 1);
        chk({tag, ".addr_hold"}, rd_addr, a);
        rd_valid = 1'b1;
        rd_open = wall_open[a];
        frame_tick = tick_on_valid;
        @(negedge Clk);
        rd_valid = 1'b0;
        frame_tick = 1'b0;
        rd_open = 1'($urandom);
        chk({tag, ".req_drop"}, rd_req, 0);
        if (!wall_open[a]) begin
            chk({tag, ".wall_bump"}, bump, 1);
            chk({tag, ".wall_busy"}, busy, 0);
            check_state({tag, ".wall"});
            cyc(1);
            chk({tag, ".wall_bump_end"}, bump, 0);
            return;
        end
        chk({tag, ".commit_busy"}, busy, 1);
        check_state({tag, ".pretick0"});
        if (gap > 1) begin
            pulse(4'($urandom_range(1, 15)));
            cyc(gap - 1);
        end else begin
            cyc(gap);
        end
        check_state({tag, ".pretick"});
        chk({tag, ".pretick_req"}, rd_req, 0);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        mx = tx;
        my = ty;
        if (mcnt < 65535) mcnt++;
        mwon = (tx == 15 && ty == 11) ? 1 : 0;
        check_state({tag, ".commit"});
        chk({tag, ".done_busy"}, busy, 0);
        chk({tag, ".done_bump"}, bump, 0);
    endtask

    initial begin
        foreach (wall_open[i]) wall_open[i] = 1'b1;
        model_reset();
        cyc(3);
        Reset = 1'b1;
        cyc(1);
        check_state("rst");
        chk("rst.req", rd_req, 0);
        chk("rst.addr", rd_addr, 0);
        chk("rst.bump", bump, 0);

        do_move("left_edge", 4'b0010, 1, 0, 0);
        do_move("right1", 4'b0001, 3, 10, 0);
        wall_open[17] = 1'b0;
        do_move("down_wall", 4'b0100, 2, 0, 0);
        wall_open[17] = 1'b1;
        do_move("down_open", 4'b0100, 1, 2, 0);
        do_move("up_right_prio", 4'b1001, 2, 3, 1);

        // Restart while the lookup is outstanding, then drain the stale response.
        pulse(4'b0001);
        chk("drain.req", rd_req, 1);
        restart_p = 1'b1;
        @(negedge Clk);
        restart_p = 1'b0;
        model_reset();
        check_state("drain");
        chk("drain.req_drop", rd_req, 0);
        chk("drain.busy", busy, 1);
        pulse(4'b0001);
        chk("drain.ignored_req", rd_req, 0);
        cyc(2);
        rd_valid = 1'b1;
        rd_open = 1'b1;
        @(negedge Clk);
        rd_valid = 1'b0;
        chk("drain.exit_busy", busy, 0);
        chk("drain.exit_req", rd_req, 0);
        check_state("drain.exit");
        do_move("after_drain", 4'b0001, 1, 1, 0);

        // Asynchronous reset mid-lookup must clear outputs before any clock edge.
        pulse(4'b0001);
        chk("areset.req_before", rd_req, 1);
        #2 Reset = 1'b0;
        #1;
        model_reset();
        chk("areset.req", rd_req, 0);
        chk("areset.busy", busy, 0);
        check_state("areset");
        @(negedge Clk);
        Reset = 1'b1;
        cyc(1);
        check_state("areset.release");

        for (int i = 0; i < 14; i++) do_move("walk_r", 4'b0001, 1, 0, 0);
        for (int i = 0; i < 11; i++) do_move("walk_d", 4'b0100, 2, 1, 0);
        do_move("goal", 4'b0001, 3, 4, 0);
        chk("goal.won", won, 1);
        do_move("won_down", 4'b0100, 1, 0, 0);
        do_move("won_right", 4'b0001, 1, 0, 0);
        do_restart("won_restart");

        for (int i = 0; i < 5; i++) do_move("sat", 4'b0001, 1, 0, 0);
        chk("sat.cnt16", move_count, 5);
        chk("sat.cnt2", move_count2, 3);

        foreach (wall_open[i]) wall_open[i] = ($urandom % 4) != 0;
        do_restart("rand_start");
        for (int i = 0; i < 120; i++) begin
            if ($urandom % 12 == 0)
                do_restart("rand_restart");
            else
                do_move("rand", 4'($urandom_range(1, 15)), $urandom_range(1, 5),
                        $urandom_range(0, 6), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
